mem_access: RTL and testbench



---
 rtl/mem_access_pkg.sv | 37 +++
 rtl/mem_access_align.sv | 64 ++++++
 rtl/mem_access.sv | 148 ++++++++++++++
 tb/tb_mem_access.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage memory access unit: bus widths, aluop codes, FSM states.
// The LL/SC codes always exist here; whether they touch memory is decided by MEM_LLSC_EN in mem_access.
package mem_access_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;

  localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'b00000000;
  localparam logic [AluOpBus-1:0] EXE_ADD_OP = 8'b00100000;
  localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b11101011;
  localparam logic [AluOpBus-1:0] EXE_LL_OP  = 8'b11110000;
  localparam logic [AluOpBus-1:0] EXE_SC_OP  = 8'b11111000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  function automatic logic is_basic_load(input logic [AluOpBus-1:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_basic_store(input logic [AluOpBus-1:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Big-endian lane logic: byte enables and replicated write data for stores,
// lane select plus sign/zero extension for loads. Purely combinational.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [AluOpBus-1:0] aluop,
  input  logic [1:0]          addr_lo,
  input  logic [RegBus-1:0]   reg2,
  input  logic [RegBus-1:0]   rdata,
  output logic [3:0]          sel,
  output logic [RegBus-1:0]   wdata,
  output logic [RegBus-1:0]   ldata
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [4:0]  byte_msb;

  assign byte_msb = 5'd31 - {addr_lo, 3'b000};
  assign rd_byte  = rdata[byte_msb -: 8];
  assign rd_half  = addr_lo[1] ? rdata[15:0] : rdata[31:16];

  always_comb begin
    sel   = 4'b0000;
    wdata = '0;
    ldata = '0;
    case (aluop)
      EXE_LB_OP: begin
        sel   = 4'b1000 >> addr_lo;
        ldata = {{24{rd_byte[7]}}, rd_byte};
      end
      EXE_LBU_OP: begin
        sel   = 4'b1000 >> addr_lo;
        ldata = {24'b0, rd_byte};
      end
      EXE_LH_OP: begin
        sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
        ldata = {{16{rd_half[15]}}, rd_half};
      end
      EXE_LHU_OP: begin
        sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
        ldata = {16'b0, rd_half};
      end
      EXE_LW_OP, EXE_LL_OP: begin
        sel   = 4'b1111;
        ldata = rdata;
      end
      EXE_SB_OP: begin
        sel   = 4'b1000 >> addr_lo;
        wdata = {4{reg2[7:0]}};
      end
      EXE_SH_OP: begin
        sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata = {2{reg2[15:0]}};
      end
      EXE_SW_OP, EXE_SC_OP: begin
        sel   = 4'b1111;
        wdata = reg2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage access unit: holds the pipeline via stallreq_mem while a data-memory request is outstanding.
// Optional LL/SC support with an llbit register when MEM_LLSC_EN is defined.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_reg,
  input  logic [RegAddrBus-1:0] ex_waddr,
  input  logic [RegBus-1:0]     ex_wdata,
  input  logic                  ex_whilo,
  input  logic [RegBus-1:0]     ex_hi,
  input  logic [RegBus-1:0]     ex_lo,
  input  logic [AluOpBus-1:0]   ex_aluop,
  input  logic [RegBus-1:0]     ex_mem_addr,
  input  logic [RegBus-1:0]     ex_reg2,
  input  logic [5:0]            stall,
  input  logic [RegBus-1:0]     dm_rdata,
  input  logic                  dm_ack,
  output logic                  mem_reg,
  output logic [RegAddrBus-1:0] mem_waddr,
  output logic [RegBus-1:0]     mem_wdata,
  output logic                  mem_whilo,
  output logic [RegBus-1:0]     mem_hi,
  output logic [RegBus-1:0]     mem_lo,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [RegBus-1:0]     dm_addr,
  output logic [3:0]            dm_sel,
  output logic [RegBus-1:0]     dm_wdata,
  output logic                  stallreq_mem
);

  mem_state_t        state;
  logic [RegBus-1:0] load_q;
  logic [3:0]        a_sel;
  logic [RegBus-1:0] a_wdata;
  logic [RegBus-1:0] a_ldata;
  logic              is_load;
  logic              is_store;
  logic              mem_op;
  logic [RegBus-1:0] wdata_c;
  logic              unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  mem_align u_align (
    .aluop   (ex_aluop),
    .addr_lo (ex_mem_addr[1:0]),
    .reg2    (ex_reg2),
    .rdata   (dm_rdata),
    .sel     (a_sel),
    .wdata   (a_wdata),
    .ldata   (a_ldata)
  );

`ifdef MEM_LLSC_EN
  logic llbit;

  // A failed SC (llbit clear) never reaches the bus and reports 0 without stalling.
  always_comb begin
    is_load  = is_basic_load(ex_aluop) || (ex_aluop == EXE_LL_OP);
    is_store = is_basic_store(ex_aluop) || ((ex_aluop == EXE_SC_OP) && llbit);
  end

  always_comb begin
    wdata_c = ex_wdata;
    if (is_load)
      wdata_c = load_q;
    else if (ex_aluop == EXE_SC_OP)
      wdata_c = {31'b0, state == ST_DONE};
  end
`else
  always_comb begin
    is_load  = is_basic_load(ex_aluop);
    is_store = is_basic_store(ex_aluop);
  end

  always_comb begin
    wdata_c = ex_wdata;
    if (is_load)
      wdata_c = load_q;
  end
`endif

  assign mem_op = is_load || is_store;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_sel   <= 4'b0000;
      dm_addr  <= '0;
      dm_wdata <= '0;
      load_q   <= '0;
`ifdef MEM_LLSC_EN
      llbit    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_op) begin
            dm_req   <= 1'b1;
            dm_we    <= is_store;
            dm_sel   <= a_sel;
            dm_addr  <= {ex_mem_addr[RegBus-1:2], 2'b00};
            dm_wdata <= is_store ? a_wdata : '0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // EX/MEM is frozen by our stall request, so the aligner still sees this access.
          if (dm_ack) begin
            load_q   <= a_ldata;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_sel   <= 4'b0000;
            dm_addr  <= '0;
            dm_wdata <= '0;
            state    <= ST_DONE;
`ifdef MEM_LLSC_EN
            if (ex_aluop == EXE_LL_OP)
              llbit <= 1'b1;
            else if (ex_aluop == EXE_SC_OP)
              llbit <= 1'b0;
`endif
          end
        end
        ST_DONE: begin
          if (!stall[4])
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stallreq_mem = !rst && (((state == ST_IDLE) && mem_op) || (state == ST_BUSY));

  assign mem_reg   = rst ? 1'b0 : ex_reg;
  assign mem_waddr = rst ? '0   : ex_waddr;
  assign mem_wdata = rst ? '0   : wdata_c;
  assign mem_whilo = rst ? 1'b0 : ex_whilo;
  assign mem_hi    = rst ? '0   : ex_hi;
  assign mem_lo    = rst ? '0   : ex_lo;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; LL/SC cases follow MEM_LLSC_EN.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_reg = 1'b0;
  logic [4:0]  ex_waddr = '0;
  logic [31:0] ex_wdata = '0;
  logic        ex_whilo = 1'b0;
  logic [31:0] ex_hi = '0;
  logic [31:0] ex_lo = '0;
  logic [7:0]  ex_aluop = EXE_NOP_OP;
  logic [31:0] ex_mem_addr = '0;
  logic [31:0] ex_reg2 = '0;
  logic [5:0]  stall = '0;
  logic [31:0] dm_rdata = '0;
  logic        dm_ack = 1'b0;
  logic        mem_reg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_sel;
  logic [31:0] dm_wdata;
  logic        stallreq_mem;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst),
    .ex_reg(ex_reg), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
    .ex_reg2(ex_reg2), .stall(stall), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_reg(mem_reg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_sel(dm_sel), .dm_wdata(dm_wdata), .stallreq_mem(stallreq_mem)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive_nop();
    @(posedge clk); #1;
    ex_aluop = EXE_NOP_OP; ex_reg = 1'b0; ex_wdata = '0; ex_mem_addr = '0; ex_reg2 = '0;
  endtask

  // Starts at posedge+1 with the FSM idle; returns at the negedge of the DONE cycle.
  task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] rdata, input int delay, output int stalls,
                         output int we_cyc, output logic [3:0] sel, output logic [31:0] dwd,
                         output logic [31:0] daddr);
    int busy;
    bit done;
    busy = 0; done = 0; stalls = 0; we_cyc = 0; sel = '0; dwd = '0; daddr = '0;
    ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2; dm_rdata = rdata;
    ex_reg = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h5A5A0000;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!stallreq_mem) begin
        done = 1;
        break;
      end
      stalls++;
      if (dm_req) begin
        if (dm_we) we_cyc++;
        sel = dm_sel; dwd = dm_wdata; daddr = dm_addr;
        dm_ack = (busy == delay);
        busy++;
      end
      @(posedge clk); #1;
      dm_ack = 1'b0;
    end
    check("access_timeout", {31'b0, done}, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] rdata;
    int          delay;
    logic [3:0]  sel;
    logic [31:0] dwd;
    logic        we;
    logic [31:0] memw;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int st, wc;
    logic [3:0]  s;
    logic [31:0] w, a;

    vecs[0] = '{EXE_LB_OP,  32'h00001001, 32'h0,        32'h11F23344, 0, 4'b0100, 32'h0,        1'b0, 32'hFFFFFFF2};
    vecs[1] = '{EXE_SH_OP,  32'h00002002, 32'h0000BEEF, 32'h0,        3, 4'b0011, 32'hBEEFBEEF, 1'b1, 32'h5A5A0000};
    vecs[2] = '{EXE_LBU_OP, 32'h00000103, 32'h0,        32'h112233F4, 1, 4'b0001, 32'h0,        1'b0, 32'h000000F4};
    vecs[3] = '{EXE_LH_OP,  32'h00000200, 32'h0,        32'h80011234, 0, 4'b1100, 32'h0,        1'b0, 32'hFFFF8001};
    vecs[4] = '{EXE_LHU_OP, 32'h00000303, 32'h0,        32'h1234F00D, 2, 4'b0011, 32'h0,        1'b0, 32'h0000F00D};
    vecs[5] = '{EXE_SB_OP,  32'h00000402, 32'h123456A5, 32'h0,        0, 4'b0010, 32'hA5A5A5A5, 1'b1, 32'h5A5A0000};
    vecs[6] = '{EXE_SW_OP,  32'h00000501, 32'hDEADBEEF, 32'h0,        1, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h5A5A0000};

    // Reset: outputs gated even with live inputs
    ex_aluop = EXE_ADD_OP; ex_reg = 1'b1; ex_wdata = 32'hABCD; ex_waddr = 5'd3;
    #12;
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_reg", {31'b0, mem_reg}, 32'h0);
    check("rst_dm_req", {31'b0, dm_req}, 32'h0);
    check("rst_stallreq", {31'b0, stallreq_mem}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-memory passthrough
    ex_aluop = EXE_ADD_OP; ex_reg = 1'b1; ex_wdata = 32'h1234; ex_waddr = 5'd7;
    ex_whilo = 1'b1; ex_hi = 32'h11110000; ex_lo = 32'h00002222;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("add_stallreq", {31'b0, stallreq_mem}, 32'h0);
    end
    check("add_wdata", mem_wdata, 32'h1234);
    check("add_reg", {31'b0, mem_reg}, 32'h1);
    check("add_waddr", {27'b0, mem_waddr}, 32'd7);
    check("add_hi", mem_hi, 32'h11110000);
    check("add_lo", mem_lo, 32'h00002222);
    check("add_dm_req", {31'b0, dm_req}, 32'h0);
    ex_whilo = 1'b0; ex_hi = '0; ex_lo = '0;
    drive_nop();

    // Load/store table
    for (int i = 0; i < 7; i++) begin
      run_mem(vecs[i].op, vecs[i].addr, vecs[i].reg2, vecs[i].rdata, vecs[i].delay, st, wc, s, w, a);
      check($sformatf("v%0d_stalls", i), st, 2 + vecs[i].delay);
      check($sformatf("v%0d_we_cycles", i), wc, vecs[i].we ? vecs[i].delay + 1 : 0);
      check($sformatf("v%0d_sel", i), {28'b0, s}, {28'b0, vecs[i].sel});
      check($sformatf("v%0d_dm_wdata", i), w, vecs[i].dwd);
      check($sformatf("v%0d_dm_addr", i), a, {vecs[i].addr[31:2], 2'b00});
      check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].memw);
      check($sformatf("v%0d_done_req", i), {31'b0, dm_req}, 32'h0);
      drive_nop();
    end

    // LW held in DONE by a downstream stall
    run_mem(EXE_LW_OP, 32'h00003003, 32'h0, 32'hCAFEF00D, 1, st, wc, s, w, a);
    check("lw_stalls", st, 3);
    check("lw_addr", a, 32'h00003000);
    check("lw_wdata", mem_wdata, 32'hCAFEF00D);
    stall = 6'b010000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("hold_stallreq", {31'b0, stallreq_mem}, 32'h0);
      check("hold_wdata", mem_wdata, 32'hCAFEF00D);
      check("hold_dm_req", {31'b0, dm_req}, 32'h0);
    end
    stall = 6'b000000;
    @(negedge clk);
    check("idle_restart_stallreq", {31'b0, stallreq_mem}, 32'h1);
    check("idle_restart_req", {31'b0, dm_req}, 32'h0);
    @(negedge clk);
    check("busy_req", {31'b0, dm_req}, 32'h1);

    // Async reset during BUSY
    rst = 1'b1;
    #1;
    check("rst_busy_req", {31'b0, dm_req}, 32'h0);
    check("rst_busy_stallreq", {31'b0, stallreq_mem}, 32'h0);
    check("rst_busy_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    ex_aluop = EXE_ADD_OP; ex_wdata = 32'h77; ex_reg = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    dm_ack = 1'b1;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(negedge clk);
    check("post_ack_req", {31'b0, dm_req}, 32'h0);
    check("post_ack_stallreq", {31'b0, stallreq_mem}, 32'h0);
    check("post_ack_wdata", mem_wdata, 32'h77);
    drive_nop();

`ifdef MEM_LLSC_EN
    run_mem(EXE_LL_OP, 32'h00000040, 32'h0, 32'h00000077, 0, st, wc, s, w, a);
    check("ll_stalls", st, 2);
    check("ll_wdata", mem_wdata, 32'h77);
    drive_nop();
    run_mem(EXE_SC_OP, 32'h00000040, 32'h00000099, 32'h0, 0, st, wc, s, w, a);
    check("sc1_stalls", st, 2);
    check("sc1_we_cycles", wc, 1);
    check("sc1_dm_wdata", w, 32'h99);
    check("sc1_sel", {28'b0, s}, 32'hF);
    check("sc1_mem_wdata", mem_wdata, 32'h1);
    drive_nop();
    ex_aluop = EXE_SC_OP; ex_mem_addr = 32'h40; ex_reg2 = 32'h99; ex_reg = 1'b1; ex_wdata = 32'h5A5A0000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("sc2_stallreq", {31'b0, stallreq_mem}, 32'h0);
      check("sc2_dm_req", {31'b0, dm_req}, 32'h0);
      check("sc2_mem_wdata", mem_wdata, 32'h0);
      check("sc2_mem_reg", {31'b0, mem_reg}, 32'h1);
    end
`else
    ex_aluop = EXE_SC_OP; ex_mem_addr = 32'h40; ex_reg2 = 32'h99; ex_reg = 1'b1; ex_wdata = 32'h31;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("sc_pass_stallreq", {31'b0, stallreq_mem}, 32'h0);
      check("sc_pass_dm_req", {31'b0, dm_req}, 32'h0);
      check("sc_pass_wdata", mem_wdata, 32'h31);
    end
    ex_aluop = EXE_LL_OP; ex_wdata = 32'h32;
    @(negedge clk);
    check("ll_pass_stallreq", {31'b0, stallreq_mem}, 32'h0);
    check("ll_pass_wdata", mem_wdata, 32'h32);
`endif
    drive_nop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
